// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: requester identities, default
// bus widths and the opcode map used by the control unit and the arbiter.
package cpu_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 11;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int OPCODE_WIDTH       = DEFAULT_DATA_WIDTH - DEFAULT_ADDR_WIDTH;

  typedef enum logic {
    REQ_CPU  = 1'b0,
    REQ_HOST = 1'b1
  } requester_t;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP   = 5'h00,
    OP_LOAD  = 5'h01,
    OP_STORE = 5'h02,
    OP_ADD   = 5'h03,
    OP_SUB   = 5'h04,
    OP_AND   = 5'h05,
    OP_OR    = 5'h06,
    OP_JMP   = 5'h07,
    OP_JZ    = 5'h08,
    OP_HALT  = 5'h1F
  } opcode_t;

  // Width of a counter that must hold 0..max inclusive.
  function automatic int burst_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way grant decision: round-robin between CPU and host, except that a
// locked host keeps winning ties until it has used up its burst allowance.
module rr_pick2
  import cpu_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int BURST_W   = burst_width(MAX_BURST)
) (
  input  logic [1:0]         req,
  input  requester_t         last_grant,
  input  logic               lock,
  input  logic [BURST_W-1:0] burst_cnt,
  output logic [1:0]         grant
);

  logic host_keeps;

  assign host_keeps = lock && (last_grant == REQ_HOST)
                      && (burst_cnt < BURST_W'(MAX_BURST));

  // NOTE: grant gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant[REQ_CPU]  = 1'b1;
      2'b10:   grant[REQ_HOST] = 1'b1;
      2'b11: begin
        if (host_keeps || last_grant == REQ_CPU) grant[REQ_HOST] = 1'b1;
        else                                     grant[REQ_CPU]  = 1'b1;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data memory between the CPU datapath and the
// host loader port; returns read data one cycle after the grant.
module data_memory_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clock_in,
  input  logic                  reset_in,

  input  logic                  cpu_req_in,
  input  logic                  cpu_we_in,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_in,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_in,
  output logic                  cpu_gnt_out,
  output logic                  cpu_stall_out,
  output logic                  cpu_rvalid_out,
  output logic [DATA_WIDTH-1:0] cpu_rdata_out,

  input  logic                  host_req_in,
  input  logic                  host_we_in,
  input  logic [ADDR_WIDTH-1:0] host_addr_in,
  input  logic [DATA_WIDTH-1:0] host_wdata_in,
  input  logic                  host_lock_in,
  output logic                  host_gnt_out,
  output logic                  host_rvalid_out,
  output logic [DATA_WIDTH-1:0] host_rdata_out,

  output logic                  mem_en_out,
  output logic                  mem_we_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_wdata_out,
  input  logic [DATA_WIDTH-1:0] mem_rdata_in
);

  localparam int BURST_W = burst_width(MAX_BURST);

  requester_t         last_grant;
  logic [BURST_W-1:0] burst_cnt;
  logic [1:0]         rd_owner;
  logic [1:0]         pick;
  logic [1:0]         gnt;

  rr_pick2 #(
    .MAX_BURST (MAX_BURST),
    .BURST_W   (BURST_W)
  ) u_pick (
    .req        ({host_req_in, cpu_req_in}),
    .last_grant (last_grant),
    .lock       (host_lock_in),
    .burst_cnt  (burst_cnt),
    .grant      (pick)
  );

  assign gnt           = reset_in ? 2'b00 : pick;
  assign cpu_gnt_out   = gnt[REQ_CPU];
  assign host_gnt_out  = gnt[REQ_HOST];
  assign cpu_stall_out = cpu_req_in & ~cpu_gnt_out;

  always_comb begin
    mem_en_out    = 1'b0;
    mem_we_out    = 1'b0;
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    if (gnt[REQ_CPU]) begin
      mem_en_out    = 1'b1;
      mem_we_out    = cpu_we_in;
      mem_addr_out  = cpu_addr_in;
      mem_wdata_out = cpu_wdata_in;
    end else if (gnt[REQ_HOST]) begin
      mem_en_out    = 1'b1;
      mem_we_out    = host_we_in;
      mem_addr_out  = host_addr_in;
      mem_wdata_out = host_wdata_in;
    end
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      last_grant <= REQ_HOST;
      burst_cnt  <= '0;
      rd_owner   <= 2'b00;
    end else begin
      if (gnt[REQ_CPU]) begin
        last_grant <= REQ_CPU;
        burst_cnt  <= '0;
      end else if (gnt[REQ_HOST]) begin
        last_grant <= REQ_HOST;
        if (burst_cnt != BURST_W'(MAX_BURST)) burst_cnt <= burst_cnt + 1'b1;
      end else begin
        burst_cnt <= '0;
      end
      rd_owner[REQ_CPU]  <= gnt[REQ_CPU]  & ~cpu_we_in;
      rd_owner[REQ_HOST] <= gnt[REQ_HOST] & ~host_we_in;
    end
  end

  // Gating with reset drops a read whose data would land during the reset cycle.
  assign cpu_rvalid_out  = rd_owner[REQ_CPU]  & ~reset_in;
  assign host_rvalid_out = rd_owner[REQ_HOST] & ~reset_in;
  assign cpu_rdata_out   = cpu_rvalid_out  ? mem_rdata_in : '0;
  assign host_rdata_out  = host_rvalid_out ? mem_rdata_in : '0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter and its rr_pick2 decision block,
// with a behavioural single-port memory hanging off the mem_* bus.
module tb_data_memory_arbiter;
  import cpu_pkg::*;

  localparam int AW = 11;
  localparam int DW = 16;

  logic          clock_in = 1'b0;
  logic          reset_in;
  logic          cpu_req_in, cpu_we_in;
  logic [AW-1:0] cpu_addr_in;
  logic [DW-1:0] cpu_wdata_in;
  logic          cpu_gnt_out, cpu_stall_out, cpu_rvalid_out;
  logic [DW-1:0] cpu_rdata_out;
  logic          host_req_in, host_we_in, host_lock_in;
  logic [AW-1:0] host_addr_in;
  logic [DW-1:0] host_wdata_in;
  logic          host_gnt_out, host_rvalid_out;
  logic [DW-1:0] host_rdata_out;
  logic          mem_en_out, mem_we_out;
  logic [AW-1:0] mem_addr_out;
  logic [DW-1:0] mem_wdata_out;
  logic [DW-1:0] mem_rdata_in;

  logic [1:0]    pk_req;
  requester_t    pk_last;
  logic          pk_lock;
  logic [2:0]    pk_cnt;
  logic [1:0]    pk_grant;

  logic [DW-1:0] mem_model [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock_in = ~clock_in;

  data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clock_in        (clock_in),
    .reset_in        (reset_in),
    .cpu_req_in      (cpu_req_in),
    .cpu_we_in       (cpu_we_in),
    .cpu_addr_in     (cpu_addr_in),
    .cpu_wdata_in    (cpu_wdata_in),
    .cpu_gnt_out     (cpu_gnt_out),
    .cpu_stall_out   (cpu_stall_out),
    .cpu_rvalid_out  (cpu_rvalid_out),
    .cpu_rdata_out   (cpu_rdata_out),
    .host_req_in     (host_req_in),
    .host_we_in      (host_we_in),
    .host_addr_in    (host_addr_in),
    .host_wdata_in   (host_wdata_in),
    .host_lock_in    (host_lock_in),
    .host_gnt_out    (host_gnt_out),
    .host_rvalid_out (host_rvalid_out),
    .host_rdata_out  (host_rdata_out),
    .mem_en_out      (mem_en_out),
    .mem_we_out      (mem_we_out),
    .mem_addr_out    (mem_addr_out),
    .mem_wdata_out   (mem_wdata_out),
    .mem_rdata_in    (mem_rdata_in)
  );

  rr_pick2 #(.MAX_BURST(4), .BURST_W(3)) u_pick (
    .req        (pk_req),
    .last_grant (pk_last),
    .lock       (pk_lock),
    .burst_cnt  (pk_cnt),
    .grant      (pk_grant)
  );

  // Memory macro model: write commits at the edge, read data registered.
  always @(posedge clock_in) begin
    if (mem_en_out && mem_we_out)  mem_model[mem_addr_out] <= mem_wdata_out;
    if (mem_en_out && !mem_we_out) mem_rdata_in <= mem_model[mem_addr_out];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic advance();
    @(posedge clock_in);
    #1;
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
    cpu_req_in = req; cpu_we_in = we; cpu_addr_in = addr; cpu_wdata_in = wdata;
  endtask

  task automatic drive_host(input logic req, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic lock);
    host_req_in = req; host_we_in = we; host_addr_in = addr; host_wdata_in = wdata;
    host_lock_in = lock;
  endtask

  task automatic pick(input string tag, input logic [1:0] req, input requester_t last,
                      input logic lock, input logic [2:0] cnt, input logic [1:0] exp);
    pk_req = req; pk_last = last; pk_lock = lock; pk_cnt = cnt;
    #1;
    check(tag, {30'd0, pk_grant}, {30'd0, exp});
  endtask

  initial begin
    mem_rdata_in = '0;
    reset_in = 1'b1;
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_host(1'b0, 1'b0, '0, '0, 1'b0);

    // Decision block alone (bit0 = CPU, bit1 = HOST).
    pick("pick_none",       2'b00, REQ_HOST, 1'b0, 3'd0, 2'b00);
    pick("pick_cpu_only",   2'b01, REQ_CPU,  1'b1, 3'd0, 2'b01);
    pick("pick_host_only",  2'b10, REQ_HOST, 1'b1, 3'd4, 2'b10);
    pick("pick_tie_lastH",  2'b11, REQ_HOST, 1'b0, 3'd0, 2'b01);
    pick("pick_tie_lastC",  2'b11, REQ_CPU,  1'b0, 3'd0, 2'b10);
    pick("pick_lock_cnt3",  2'b11, REQ_HOST, 1'b1, 3'd3, 2'b10);
    pick("pick_lock_cnt4",  2'b11, REQ_HOST, 1'b1, 3'd4, 2'b01);
    pick("pick_lock_lastC", 2'b11, REQ_CPU,  1'b1, 3'd0, 2'b10);

    advance();
    drive_cpu(1'b1, 1'b0, 11'h002, '0);
    drive_host(1'b1, 1'b0, 11'h001, '0, 1'b0);
    #1;
    check("rst_cpu_gnt",  cpu_gnt_out,  0);
    check("rst_host_gnt", host_gnt_out, 0);
    check("rst_mem_en",   mem_en_out,   0);

    advance();
    reset_in = 1'b0;
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_host(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    check("idle_cpu_gnt",    cpu_gnt_out,     0);
    check("idle_host_gnt",   host_gnt_out,    0);
    check("idle_mem_en",     mem_en_out,      0);
    check("idle_mem_addr",   mem_addr_out,    0);
    check("idle_cpu_rvalid", cpu_rvalid_out,  0);
    check("idle_host_rvalid",host_rvalid_out, 0);

    // Host loader preloads memory.
    advance(); drive_host(1'b1, 1'b1, 11'h001, 16'hAAAA, 1'b0); #1;
    check("pre1_host_gnt", host_gnt_out, 1);
    check("pre1_mem_we",   mem_we_out,   1);
    check("pre1_mem_addr", mem_addr_out, 32'h001);
    advance(); drive_host(1'b1, 1'b1, 11'h002, 16'h5555, 1'b0); #1;
    check("pre2_mem_wdata", mem_wdata_out, 32'h5555);
    advance(); drive_host(1'b1, 1'b1, 11'h010, 16'hBEEF, 1'b0); #1;
    check("pre3_host_gnt", host_gnt_out, 1);
    advance(); drive_host(1'b0, 1'b0, '0, '0, 1'b0); #1;
    check("pre_no_rvalid", host_rvalid_out, 0);

    // CPU read at 0x010, then reset before the data returns.
    advance(); drive_cpu(1'b1, 1'b0, 11'h010, '0); #1;
    check("mr_cpu_gnt",  cpu_gnt_out,  1);
    check("mr_mem_we",   mem_we_out,   0);
    check("mr_mem_addr", mem_addr_out, 32'h010);
    advance();
    reset_in = 1'b1;
    drive_cpu(1'b1, 1'b0, 11'h002, '0);
    drive_host(1'b1, 1'b0, 11'h001, '0, 1'b0);
    #1;
    check("mr_rst_rvalid",   cpu_rvalid_out, 0);
    check("mr_rst_cpu_gnt",  cpu_gnt_out,    0);
    check("mr_rst_host_gnt", host_gnt_out,   0);
    check("mr_rst_mem_en",   mem_en_out,     0);
    check("mr_rst_stall",    cpu_stall_out,  1);

    // Contention, no lock: CPU wins the first tie after reset, then alternate.
    advance(); reset_in = 1'b0; #1;
    check("c0_cpu_gnt",    cpu_gnt_out,    1);
    check("c0_host_gnt",   host_gnt_out,   0);
    check("c0_stall",      cpu_stall_out,  0);
    check("c0_cpu_rvalid", cpu_rvalid_out, 0);
    check("c0_mem_addr",   mem_addr_out,   32'h002);
    advance(); #1;
    check("c1_host_gnt",    host_gnt_out,    1);
    check("c1_cpu_gnt",     cpu_gnt_out,     0);
    check("c1_stall",       cpu_stall_out,   1);
    check("c1_cpu_rvalid",  cpu_rvalid_out,  1);
    check("c1_cpu_rdata",   cpu_rdata_out,   32'h5555);
    check("c1_host_rvalid", host_rvalid_out, 0);
    check("c1_host_rdata",  host_rdata_out,  0);
    advance(); #1;
    check("c2_cpu_gnt",     cpu_gnt_out,     1);
    check("c2_stall",       cpu_stall_out,   0);
    check("c2_host_rvalid", host_rvalid_out, 1);
    check("c2_host_rdata",  host_rdata_out,  32'hAAAA);
    check("c2_cpu_rvalid",  cpu_rvalid_out,  0);
    check("c2_cpu_rdata",   cpu_rdata_out,   0);
    advance(); #1;
    check("c3_host_gnt",   host_gnt_out,   1);
    check("c3_cpu_rdata",  cpu_rdata_out,  32'h5555);
    check("c3_host_rdata", host_rdata_out, 0);

    // Host lock: host already holds one grant, three more, then CPU, then host.
    advance(); host_lock_in = 1'b1; #1;
    check("l4_host_gnt", host_gnt_out, 1);
    check("l4_stall",    cpu_stall_out, 1);
    advance(); #1;
    check("l5_host_gnt", host_gnt_out, 1);
    advance(); #1;
    check("l6_host_gnt", host_gnt_out, 1);
    check("l6_stall",    cpu_stall_out, 1);
    advance(); #1;
    check("l7_cpu_gnt",  cpu_gnt_out,  1);
    check("l7_host_gnt", host_gnt_out, 0);
    check("l7_stall",    cpu_stall_out, 0);
    advance(); #1;
    check("l8_host_gnt", host_gnt_out, 1);
    check("l8_cpu_rvalid", cpu_rvalid_out, 1);

    advance();
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_host(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    check("l9_mem_en",       mem_en_out,      0);
    check("l9_host_rvalid",  host_rvalid_out, 1);
    check("l9_host_rdata",   host_rdata_out,  32'hAAAA);

    // CPU only: store then load.
    advance(); drive_cpu(1'b1, 1'b1, 11'h005, 16'h1234); #1;
    check("st_cpu_gnt",   cpu_gnt_out,   1);
    check("st_stall",     cpu_stall_out, 0);
    check("st_mem_we",    mem_we_out,    1);
    check("st_mem_wdata", mem_wdata_out, 32'h1234);
    advance(); drive_cpu(1'b1, 1'b0, 11'h005, '0); #1;
    check("ld_cpu_gnt",    cpu_gnt_out,    1);
    check("ld_no_wrvalid", cpu_rvalid_out, 0);
    advance(); drive_cpu(1'b0, 1'b0, '0, '0); #1;
    check("ld_cpu_rvalid",  cpu_rvalid_out,  1);
    check("ld_cpu_rdata",   cpu_rdata_out,   32'h1234);
    check("ld_host_rvalid", host_rvalid_out, 0);

    // Lone locked host is granted every cycle past MAX_BURST.
    advance(); drive_host(1'b1, 1'b0, 11'h010, '0, 1'b1); #1;
    check("h0_host_gnt", host_gnt_out, 1);
    for (int i = 1; i < 6; i++) begin
      advance(); #1;
      check($sformatf("h%0d_host_gnt", i), host_gnt_out, 1);
      check($sformatf("h%0d_host_rdata", i), host_rdata_out, 32'hBEEF);
    end
    // Burst counter is saturated, so an arriving CPU wins at once.
    advance(); drive_cpu(1'b1, 1'b0, 11'h005, '0); #1;
    check("sat_cpu_gnt",  cpu_gnt_out,   1);
    check("sat_host_gnt", host_gnt_out,  0);
    check("sat_stall",    cpu_stall_out, 0);
    advance(); drive_cpu(1'b0, 1'b0, '0, '0); drive_host(1'b0, 1'b0, '0, '0, 1'b0); #1;
    check("sat_cpu_rdata", cpu_rdata_out, 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
